mem_arbiter: RTL and testbench

- Sits directly downstream of the single-cycle CPU core's instruction-fetch and data-access ports.
- Arbitrates both ports onto one single-ported, synchronous-read unified memory, so the instruction and data arrays merge into one RAM.
- Exposes a level-request / one-cycle-valid handshake per port.
- The CPU holds PC_en low and freezes state until its outstanding request completes.

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter_rr_arbiter2.sv | 57 +++++
 rtl/mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the unified-memory arbiter: FSM state encoding,
// port identifiers and a small helper used by the round-robin grant logic.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    // Arbiter FSM states; encodings are fixed so they read the same in waves
    // and in any external debug tooling.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Requesting-port identifiers.
    localparam logic GNT_INST = 1'b0;
    localparam logic GNT_DATA = 1'b1;

    // Returns the port that is not `id`; used to alternate on a collision.
    function automatic logic other_port(input logic id);
        return (id == GNT_INST) ? GNT_DATA : GNT_INST;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin grant. When both requests are present the port
// that did not win last time is chosen. The last-grant register only moves
// when a grant is actually issued (i_grant_en high and at least one request).
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset (last grant -> INST)
//   i_req_inst  instruction port eligible to be granted
//   i_req_data  data port eligible to be granted
//   i_grant_en  arbitration allowed this cycle
//   o_gnt       a grant is issued this cycle (combinational)
//   o_gnt_id    granted port ID (valid when o_gnt=1)
// -----------------------------------------------------------------------------
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req_inst,
    input  logic i_req_data,
    input  logic i_grant_en,
    output logic o_gnt,
    output logic o_gnt_id
);

    logic r_last_grant;
    logic w_gnt_id;

    // Grant selection: lone requester wins, collisions alternate.
    always_comb begin
        w_gnt_id = GNT_INST;
        if (i_req_inst && i_req_data) begin
            w_gnt_id = other_port(r_last_grant);
        end else if (i_req_data) begin
            w_gnt_id = GNT_DATA;
        end else begin
            w_gnt_id = GNT_INST;
        end
    end

    assign o_gnt    = i_grant_en & (i_req_inst | i_req_data);
    assign o_gnt_id = w_gnt_id;

    // Last-grant history; reset to INST so data wins the first collision.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_grant <= GNT_INST;
        end else if (o_gnt) begin
            r_last_grant <= w_gnt_id;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-ported, synchronous-read unified memory between the CPU
// instruction-fetch port and data port. Each port uses a level request that is
// held until a one-cycle valid pulse. Every access takes exactly three cycles:
// grant in IDLE, memory enable in ACCESS, read-data capture in RESP, with the
// valid pulse appearing in the cycle after RESP.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   if_req     fetch request (level)           if_addr   fetch byte address
//   if_rdata   fetched word (registered)       if_valid  fetch complete pulse
//   d_req      data request (level)            d_we      1=store, 0=load
//   d_addr     data byte address               d_wdata   store data
//   d_rdata    load data (registered)          d_valid   data complete pulse
//   busy       FSM not in IDLE
//   mem_en     memory enable                   mem_we    memory write enable
//   mem_addr   memory word address             mem_wdata memory write data
//   mem_rdata  memory read data (one cycle after a read enable)
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_port;
    logic [ADDR_W-3:0]   r_addr;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_if_valid;
    logic                r_d_valid;

    logic                w_if_elig;
    logic                w_d_elig;
    logic                w_grant_en;
    logic                w_gnt;
    logic                w_gnt_id;
    logic                w_unused_lsbs;

    // Byte-lane bits of the addresses are ignored: the memory is word-wide.
    assign w_unused_lsbs = ^{if_addr[1:0], d_addr[1:0]};

    // A port whose valid is high this cycle is still holding the request it
    // just completed, so it must not be granted again.
    assign w_if_elig  = if_req & ~r_if_valid;
    assign w_d_elig   = d_req  & ~r_d_valid;
    assign w_grant_en = (r_state == ST_IDLE);

    rr_arbiter2 u_rr_arbiter2 (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_req_inst (w_if_elig),
        .i_req_data (w_d_elig),
        .i_grant_en (w_grant_en),
        .o_gnt      (w_gnt),
        .o_gnt_id   (w_gnt_id)
    );

    // Next-state logic: IDLE waits for a grant, ACCESS and RESP last one cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt) begin
                    w_next_state = ST_ACCESS;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ACCESS: w_next_state = ST_RESP;
            ST_RESP:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Transaction latches: inputs are sampled only at grant time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_port  <= GNT_INST;
            r_addr  <= {(ADDR_W-2){1'b0}};
            r_we    <= 1'b0;
            r_wdata <= {DATA_W{1'b0}};
        end else if (w_gnt) begin
            r_port <= w_gnt_id;
            if (w_gnt_id == GNT_DATA) begin
                r_addr  <= d_addr[ADDR_W-1:2];
                r_we    <= d_we;
                r_wdata <= d_wdata;
            end else begin
                r_addr  <= if_addr[ADDR_W-1:2];
                r_we    <= 1'b0;
                r_wdata <= {DATA_W{1'b0}};
            end
        end else begin
            r_port  <= r_port;
            r_addr  <= r_addr;
            r_we    <= r_we;
            r_wdata <= r_wdata;
        end
    end

    // Response stage: capture read data for loads/fetches and raise the
    // granted port's valid for exactly one cycle. Stores leave rdata alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_rdata <= {DATA_W{1'b0}};
            r_d_rdata  <= {DATA_W{1'b0}};
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
        end else if (r_state == ST_RESP) begin
            r_if_valid <= (r_port == GNT_INST);
            r_d_valid  <= (r_port == GNT_DATA);
            if (!r_we && (r_port == GNT_INST)) begin
                r_if_rdata <= mem_rdata;
                r_d_rdata  <= r_d_rdata;
            end else if (!r_we && (r_port == GNT_DATA)) begin
                r_if_rdata <= r_if_rdata;
                r_d_rdata  <= mem_rdata;
            end else begin
                r_if_rdata <= r_if_rdata;
                r_d_rdata  <= r_d_rdata;
            end
        end else begin
            r_if_rdata <= r_if_rdata;
            r_d_rdata  <= r_d_rdata;
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
        end
    end

    // Outputs come only from state and latched registers, so an asynchronous
    // reset drops mem_en/mem_we in the same instant.
    assign if_rdata  = r_if_rdata;
    assign if_valid  = r_if_valid;
    assign d_rdata   = r_d_rdata;
    assign d_valid   = r_d_valid;
    assign busy      = (r_state != ST_IDLE);
    assign mem_en    = (r_state == ST_ACCESS);
    assign mem_we    = (r_state == ST_ACCESS) & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with a behavioural synchronous-read RAM.
// Inputs change 1 time unit after a rising edge; outputs are checked on the
// falling edge. "cN" comments count cycles from the cycle a request appears.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [7:0]  if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req;
    logic        d_we;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        busy;
    logic        mem_en;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] tb_mem [0:63];

    int n_checks;
    int n_fail;

    mem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-ported RAM model; fixed contents are loaded while reset is low.
    always @(posedge clk) begin
        if (!rst) begin
            tb_mem[4] <= 32'h00A0_0093;
            tb_mem[5] <= 32'h1234_5678;
        end else if (mem_en) begin
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0; if_req = 1'b0; if_addr = 8'h00;
        d_req = 1'b0; d_we = 1'b0; d_addr = 8'h00; d_wdata = 32'h0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1; mid();
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_if_valid", {31'h0, if_valid}, 32'h0);
        check("rst_d_valid", {31'h0, d_valid}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_mem_en", {31'h0, mem_en}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_mem_addr", {26'h0, mem_addr}, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        adv(); rst = 1'b1;

        // ---- single fetch of 0x10, request held one cycle past if_valid ----
        if_req = 1'b1; if_addr = 8'h10;                 // c0
        mid(); check("f_c0_busy", {31'h0, busy}, 32'h0);
        adv();                                          // c1
        mid();
        check("f_c1_mem_en", {31'h0, mem_en}, 32'h1);
        check("f_c1_mem_addr", {26'h0, mem_addr}, 32'h4);
        check("f_c1_mem_we", {31'h0, mem_we}, 32'h0);
        check("f_c1_busy", {31'h0, busy}, 32'h1);
        adv();                                          // c2
        mid();
        check("f_c2_mem_en", {31'h0, mem_en}, 32'h0);
        check("f_c2_if_valid", {31'h0, if_valid}, 32'h0);
        adv();                                          // c3
        mid();
        check("f_c3_if_valid", {31'h0, if_valid}, 32'h1);
        check("f_c3_if_rdata", if_rdata, 32'h00A0_0093);
        check("f_c3_d_valid", {31'h0, d_valid}, 32'h0);
        check("f_c3_busy", {31'h0, busy}, 32'h0);
        adv(); if_req = 1'b0;                           // c4: held request not re-granted
        mid();
        check("hold_c4_mem_en", {31'h0, mem_en}, 32'h0);
        check("hold_c4_busy", {31'h0, busy}, 32'h0);
        check("hold_c4_if_valid", {31'h0, if_valid}, 32'h0);
        adv();                                          // c5
        mid();
        check("hold_c5_mem_en", {31'h0, mem_en}, 32'h0);

        // ---- store 0xDEADBEEF to 0x24; inputs change after grant ----
        adv(); d_req = 1'b1; d_we = 1'b1; d_addr = 8'h24; d_wdata = 32'hDEAD_BEEF;  // c0
        adv(); d_addr = 8'h00; d_wdata = 32'h1111_1111;                          // c1
        mid();
        check("st_c1_mem_en", {31'h0, mem_en}, 32'h1);
        check("st_c1_mem_we", {31'h0, mem_we}, 32'h1);
        check("st_c1_mem_addr", {26'h0, mem_addr}, 32'h9);
        check("st_c1_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        adv();                                          // c2
        adv(); d_req = 1'b0; d_we = 1'b0;               // c3
        mid();
        check("st_c3_d_valid", {31'h0, d_valid}, 32'h1);
        check("st_c3_d_rdata", d_rdata, 32'h0);
        check("st_c3_if_rdata", if_rdata, 32'h00A0_0093);
        adv();                                          // c4
        mid();
        check("st_c4_d_valid", {31'h0, d_valid}, 32'h0);
        check("st_c4_busy", {31'h0, busy}, 32'h0);

        // ---- load from 0x27: low bits ignored, same word as 0x24 ----
        adv(); d_req = 1'b1; d_we = 1'b0; d_addr = 8'h27;   // c0
        adv(); d_addr = 8'h00;                              // c1
        mid();
        check("ld_c1_mem_en", {31'h0, mem_en}, 32'h1);
        check("ld_c1_mem_we", {31'h0, mem_we}, 32'h0);
        check("ld_c1_mem_addr", {26'h0, mem_addr}, 32'h9);
        adv();                                              // c2
        adv(); d_req = 1'b0;                                // c3
        mid();
        check("ld_c3_d_valid", {31'h0, d_valid}, 32'h1);
        check("ld_c3_d_rdata", d_rdata, 32'hDEAD_BEEF);
        check("ld_c3_if_valid", {31'h0, if_valid}, 32'h0);

        // ---- reset asserted during ACCESS of a load from 0x14 ----
        adv(); d_req = 1'b1; d_addr = 8'h14;                // c0
        adv();                                              // c1
        mid();
        check("rm_c1_mem_en", {31'h0, mem_en}, 32'h1);
        #1; rst = 1'b0; d_req = 1'b0;
        #1;
        check("rm_mem_en_async", {31'h0, mem_en}, 32'h0);
        check("rm_busy_async", {31'h0, busy}, 32'h0);
        check("rm_mem_addr_async", {26'h0, mem_addr}, 32'h0);
        adv(); rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mid();
            check("rm_no_d_valid", {31'h0, d_valid}, 32'h0);
            check("rm_no_if_valid", {31'h0, if_valid}, 32'h0);
            check("rm_busy", {31'h0, busy}, 32'h0);
            adv();
        end
        check("rm_d_rdata", d_rdata, 32'h0);
        check("rm_if_rdata", if_rdata, 32'h0);

        // ---- collision after reset: data first, then fetch ----
        if_req = 1'b1; if_addr = 8'h10;                     // c0
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h24;
        adv();                                              // c1
        mid();
        check("c1_c1_mem_addr", {26'h0, mem_addr}, 32'h9);
        check("c1_c1_mem_en", {31'h0, mem_en}, 32'h1);
        adv();                                              // c2
        adv(); d_req = 1'b0;                                // c3
        mid();
        check("c1_c3_d_valid", {31'h0, d_valid}, 32'h1);
        check("c1_c3_d_rdata", d_rdata, 32'hDEAD_BEEF);
        check("c1_c3_if_valid", {31'h0, if_valid}, 32'h0);
        adv();                                              // c4
        mid();
        check("c1_c4_mem_en", {31'h0, mem_en}, 32'h1);
        check("c1_c4_mem_addr", {26'h0, mem_addr}, 32'h4);
        adv();                                              // c5
        adv(); if_req = 1'b0;                               // c6
        mid();
        check("c1_c6_if_valid", {31'h0, if_valid}, 32'h1);
        check("c1_c6_if_rdata", if_rdata, 32'h00A0_0093);
        check("c1_c6_d_valid", {31'h0, d_valid}, 32'h0);

        // ---- lone store to 0x30 leaves DATA as the last grant ----
        adv(); d_req = 1'b1; d_we = 1'b1; d_addr = 8'h30; d_wdata = 32'h55AA_33CC;  // c0
        adv();                                              // c1
        mid();
        check("s2_c1_mem_we", {31'h0, mem_we}, 32'h1);
        check("s2_c1_mem_addr", {26'h0, mem_addr}, 32'hC);
        adv();                                              // c2
        adv(); d_req = 1'b0; d_we = 1'b0;                   // c3
        mid();
        check("s2_c3_d_valid", {31'h0, d_valid}, 32'h1);

        // ---- collision with last grant DATA: fetch first, then data ----
        adv(); if_req = 1'b1; if_addr = 8'h10;              // c0
        d_req = 1'b1; d_addr = 8'h30;
        adv();                                              // c1
        mid();
        check("c2_c1_mem_addr", {26'h0, mem_addr}, 32'h4);
        check("c2_c1_mem_we", {31'h0, mem_we}, 32'h0);
        adv();                                              // c2
        adv(); if_req = 1'b0;                               // c3
        mid();
        check("c2_c3_if_valid", {31'h0, if_valid}, 32'h1);
        check("c2_c3_d_valid", {31'h0, d_valid}, 32'h0);
        adv();                                              // c4
        mid();
        check("c2_c4_mem_en", {31'h0, mem_en}, 32'h1);
        check("c2_c4_mem_addr", {26'h0, mem_addr}, 32'hC);
        adv();                                              // c5
        adv(); d_req = 1'b0;                                // c6
        mid();
        check("c2_c6_d_valid", {31'h0, d_valid}, 32'h1);
        check("c2_c6_d_rdata", d_rdata, 32'h55AA_33CC);
        check("c2_c6_if_valid", {31'h0, if_valid}, 32'h0);
        adv();
        mid();
        check("end_busy", {31'h0, busy}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
